// File: rtl/ff_fifo_reader_serializer.sv
// Drains wide words from a FIFO pop interface and streams them as narrow valid/ready chunks.
// Build option: define FF_FIFO_READER_MSB_FIRST_EN to emit chunks MSB-first (default LSB-first).
module ff_fifo_reader_serializer #(
    parameter  int in_width  = 16,
    parameter  int out_width = 4,
    localparam int ratio     = in_width / out_width,
    localparam int idx_width = (ratio > 1) ? $clog2(ratio) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [in_width-1:0]  fifo_read_data,
    output logic                 fifo_pop,
    output logic                 down_valid,
    input  logic                 down_ready,
    output logic [out_width-1:0] down_data,
    output logic                 down_last,
    output logic                 busy,
    output logic [15:0]          words_sent
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [idx_width-1:0] last_idx = idx_width'(ratio - 1);

    state_t               state_q, state_d;
    logic [in_width-1:0]  word_q, word_d;
    logic [idx_width-1:0] idx_q, idx_d;
    logic [15:0]          words_sent_q, words_sent_d;
    logic [out_width-1:0] chunk;
    logic                 is_last;
    logic                 handshake;

    // Mux out the chunk addressed by idx_q; the word itself never shifts.
    always_comb begin
        chunk = '0;
        for (int k = 0; k < ratio; k++) begin
            if (idx_q == idx_width'(k)) begin
`ifdef FF_FIFO_READER_MSB_FIRST_EN
                chunk = word_q[in_width-1-k*out_width -: out_width];
`else
                chunk = word_q[k*out_width +: out_width];
`endif
            end
        end
    end

    assign is_last    = (state_q == SHIFT) && (idx_q == last_idx);
    assign handshake  = (state_q == SHIFT) && down_ready;
    assign down_valid = (state_q == SHIFT);
    assign busy       = (state_q == SHIFT);
    assign down_data  = chunk;
    assign down_last  = is_last;
    assign words_sent = words_sent_q;

    // A last-chunk handshake with a non-empty FIFO reloads in place so words stream without a bubble.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        idx_d        = idx_q;
        words_sent_d = words_sent_q;
        fifo_pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !rst) begin
                    fifo_pop = 1'b1;
                    word_d   = fifo_read_data;
                    idx_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (handshake) begin
                    if (!is_last) begin
                        idx_d = idx_q + idx_width'(1);
                    end else begin
                        words_sent_d = words_sent_q + 16'd1;
                        if (!fifo_empty && !rst) begin
                            fifo_pop = 1'b1;
                            word_d   = fifo_read_data;
                            idx_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            word_q       <= '0;
            idx_q        <= '0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            words_sent_q <= words_sent_d;
        end
    end

endmodule

// File: tb/tb_ff_fifo_reader_serializer.sv
// Scoreboard bench: a queue-based FIFO feeds the DUT and a chunk queue predicts every downstream transfer.
`timescale 1ns/1ps
module tb_ff_fifo_reader_serializer;

    localparam int IN_W  = 16;
    localparam int OUT_W = 4;
    localparam int RATIO = IN_W / OUT_W;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } chunk_t;

    logic             clk            = 1'b0;
    logic             rst            = 1'b1;
    logic             fifo_empty     = 1'b1;
    logic [IN_W-1:0]  fifo_read_data = '0;
    logic             fifo_pop;
    logic             down_valid;
    logic             down_ready     = 1'b0;
    logic [OUT_W-1:0] down_data;
    logic             down_last;
    logic             busy;
    logic [15:0]      words_sent;

    logic [IN_W-1:0] fifo_q[$];
    chunk_t          exp_q[$];
    logic            exp_busy   = 1'b0;
    logic [15:0]     exp_count  = '0;
    int              checks     = 0;
    int              errors     = 0;
    int              dut_hs     = 0;
    logic            prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data = '0;
    logic            prev_last  = 1'b0;
    logic            just_reset = 1'b0;

    ff_fifo_reader_serializer #(.in_width(IN_W), .out_width(OUT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_read_data(fifo_read_data),
        .fifo_pop      (fifo_pop),
        .down_valid    (down_valid),
        .down_ready    (down_ready),
        .down_data     (down_data),
        .down_last     (down_last),
        .busy          (busy),
        .words_sent    (words_sent)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void refresh_fifo();
        fifo_empty     = (fifo_q.size() == 0);
        fifo_read_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endfunction

    // Push a word into the FIFO model and predict its chunks from the word value alone.
    task automatic apply_stimulus(input logic [IN_W-1:0] word);
        chunk_t c;
        int     shift;
        fifo_q.push_back(word);
        refresh_fifo();
        for (int k = 0; k < RATIO; k++) begin
`ifdef FF_FIFO_READER_MSB_FIRST_EN
            shift = (RATIO - 1 - k) * OUT_W;
`else
            shift = k * OUT_W;
`endif
            c.data = OUT_W'(word >> shift);
            c.last = (k == RATIO - 1);
            exp_q.push_back(c);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int   n = 0;
        logic drained;
        drained = (fifo_q.size() == 0) && (exp_q.size() == 0) && !exp_busy;
        while (!drained && n < budget) begin
            next_cycle();
            n++;
            drained = (fifo_q.size() == 0) && (exp_q.size() == 0) && !exp_busy;
        end
        next_cycle();
        check_output("drain_within_budget", 32'(drained), 1);
    endtask

    // The FIFO model pops just after an edge at which the DUT requested it.
    always @(posedge clk) begin
        logic popped;
        popped = fifo_pop;
        #1;
        if (popped && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            refresh_fifo();
        end
    end

    // Monitor: compares DUT outputs with the model every cycle, then advances the model.
    always @(negedge clk) begin
        chunk_t front;
        logic   exp_pop;
        if (down_valid && down_ready && !rst) dut_hs++;
        if (rst) begin
            check_output("pop_during_reset", 32'(fifo_pop), 0);
            if (exp_busy) begin
                while (exp_q.size() > 0) begin
                    front = exp_q.pop_front();
                    if (front.last) break;
                end
            end
            exp_busy   = 1'b0;
            exp_count  = '0;
            prev_stall = 1'b0;
            just_reset = 1'b1;
        end else begin
            if (just_reset) begin
                check_output("reset_down_data", 32'(down_data), 0);
                check_output("reset_down_last", 32'(down_last), 0);
                just_reset = 1'b0;
            end
            check_output("down_valid", 32'(down_valid), 32'(exp_busy));
            check_output("busy", 32'(busy), 32'(exp_busy));
            check_output("words_sent", 32'(words_sent), 32'(exp_count));
            front   = (exp_q.size() > 0) ? exp_q[0] : '0;
            exp_pop = !fifo_empty && (!exp_busy || (down_ready && front.last));
            check_output("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
            if (exp_busy) begin
                check_output("chunk_pending", 32'(exp_q.size() > 0), 1);
                check_output("down_data", 32'(down_data), 32'(front.data));
                check_output("down_last", 32'(down_last), 32'(front.last));
            end
            if (prev_stall) begin
                check_output("hold_data", 32'(down_data), 32'(prev_data));
                check_output("hold_last", 32'(down_last), 32'(prev_last));
            end
            prev_stall = exp_busy && !down_ready;
            prev_data  = down_data;
            prev_last  = down_last;
            if (exp_busy && down_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                if (front.last) begin
                    exp_count = exp_count + 16'd1;
                    exp_busy  = !fifo_empty;
                end
            end else if (!exp_busy && !fifo_empty) begin
                exp_busy = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;

        $display("[TB] reset with empty FIFO");
        reset_dut();
        repeat (10) next_cycle();
        check_output("idle_words_sent", 32'(words_sent), 0);

        $display("[TB] single word 0xA5C3");
        down_ready = 1'b1;
        apply_stimulus(16'hA5C3);
        wait_drain(20);
        check_output("words_after_single", 32'(words_sent), 1);

        $display("[TB] back-to-back 0x1234, 0xBEEF");
        reset_dut();
        down_ready = 1'b1;
        apply_stimulus(16'h1234);
        apply_stimulus(16'hBEEF);
        wait_drain(30);
        check_output("words_after_pair", 32'(words_sent), 2);

        $display("[TB] 0x0F0F with ready pattern 1,0,0");
        reset_dut();
        base = dut_hs;
        apply_stimulus(16'h0F0F);
        n = 0;
        while (((fifo_q.size() != 0) || (exp_q.size() != 0) || exp_busy) && n < 40) begin
            down_ready = (n % 3 == 0);
            next_cycle();
            n++;
        end
        down_ready = 1'b0;
        repeat (2) next_cycle();
        check_output("stall_handshakes", 32'(dut_hs - base), 4);
        check_output("words_after_stall", 32'(words_sent), 1);

        $display("[TB] reset mid-word");
        reset_dut();
        down_ready = 1'b1;
        base = dut_hs;
        apply_stimulus(16'hA5C3);
        n = 0;
        while (dut_hs < base + 2 && n < 20) begin
            next_cycle();
            n++;
        end
        check_output("two_chunks_before_reset", 32'(dut_hs - base), 2);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        check_output("midword_valid", 32'(down_valid), 0);
        check_output("midword_words_sent", 32'(words_sent), 0);
        base = dut_hs;
        repeat (8) next_cycle();
        check_output("no_leftover_chunks", 32'(dut_hs - base), 0);

        $display("[TB] words_sent wrap");
        reset_dut();
        down_ready = 1'b1;
        force dut.words_sent_q = 16'hFFFE;
        exp_count = 16'hFFFE;
        next_cycle();
        release dut.words_sent_q;
        next_cycle();
        apply_stimulus(16'h5A5A);
        apply_stimulus(16'hC0DE);
        wait_drain(30);
        check_output("words_wrapped", 32'(words_sent), 0);

        $display("[TB] random traffic");
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            down_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0 && fifo_q.size() < 8)
                apply_stimulus(IN_W'($urandom));
            next_cycle();
        end
        down_ready = 1'b1;
        wait_drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
